// File: rtl/board_access_arbiter.sv
// Round-robin arbiter sharing the single-ported board tile memory between actor
// controllers; one access in flight at a time, read data routed back to the winner.
module board_access_arbiter #(
  parameter int N_REQ   = 5,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ-1:0]          i_we,
  input  logic [N_REQ*ADDR_W-1:0]   i_addr,
  input  logic [N_REQ*DATA_W-1:0]   i_wdata,
  input  logic                      i_hold,
  output logic [N_REQ-1:0]          o_gnt,
  output logic [N_REQ-1:0]          o_rvalid,
  output logic [DATA_W-1:0]         o_rdata,
  output logic                      o_busy,
  output logic                      o_mem_en,
  output logic                      o_mem_we,
  output logic [ADDR_W-1:0]         o_mem_addr,
  output logic [DATA_W-1:0]         o_mem_wdata,
  input  logic [DATA_W-1:0]         i_mem_rdata
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {IDLE, CMD, WAIT, RESP} state_t;

  state_t            state, state_nx;
  logic [PTR_W-1:0]  ptr, ptr_nx;
  logic [PTR_W-1:0]  w_q, w_nx;
  logic [PTR_W-1:0]  scan_idx, win_idx;
  logic              win_found;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [DATA_W-1:0] cap_q, cap_nx;
  logic [N_REQ-1:0]  gnt_nx, rvalid_nx;
  logic [DATA_W-1:0] rdata_nx, mem_wdata_nx;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic              mem_en_nx, mem_we_nx, busy_nx;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      scan_idx = PTR_W'((int'(ptr) + i) % N_REQ);
      if (i_req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Outputs are computed one state early so every port comes straight from a flop.
  always_comb begin
    state_nx     = state;
    ptr_nx       = ptr;
    w_nx         = w_q;
    cnt_nx       = cnt;
    cap_nx       = cap_q;
    gnt_nx       = '0;
    rvalid_nx    = '0;
    rdata_nx     = o_rdata;
    mem_en_nx    = 1'b0;
    mem_we_nx    = o_mem_we;
    mem_addr_nx  = o_mem_addr;
    mem_wdata_nx = o_mem_wdata;
    case (state)
      IDLE: begin
        if (!i_hold && win_found) begin
          w_nx             = win_idx;
          gnt_nx[win_idx]  = 1'b1;
          mem_en_nx        = 1'b1;
          mem_we_nx        = i_we[win_idx];
          mem_addr_nx      = i_addr[int'(win_idx)*ADDR_W +: ADDR_W];
          mem_wdata_nx     = i_wdata[int'(win_idx)*DATA_W +: DATA_W];
          state_nx         = CMD;
        end
      end
      CMD: begin
        ptr_nx = (w_q == PTR_W'(N_REQ - 1)) ? '0 : w_q + 1'b1;
        if (o_mem_we) begin
          state_nx = IDLE;
        end else begin
          cnt_nx   = CNT_W'(MEM_LAT - 1);
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          cap_nx   = i_mem_rdata;
          state_nx = RESP;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      RESP: begin
        rvalid_nx[w_q] = 1'b1;
        rdata_nx       = cap_q;
        state_nx       = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      o_gnt       <= '0;
      o_rvalid    <= '0;
      o_rdata     <= '0;
      o_busy      <= 1'b0;
      o_mem_en    <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
    end else begin
      state       <= state_nx;
      ptr         <= ptr_nx;
      o_gnt       <= gnt_nx;
      o_rvalid    <= rvalid_nx;
      o_rdata     <= rdata_nx;
      o_busy      <= busy_nx;
      o_mem_en    <= mem_en_nx;
      o_mem_we    <= mem_we_nx;
      o_mem_addr  <= mem_addr_nx;
      o_mem_wdata <= mem_wdata_nx;
    end
  end

  // Winner, wait counter and captured data are only consumed after being loaded.
  always_ff @(posedge i_clk) begin
    w_q   <= w_nx;
    cnt   <= cnt_nx;
    cap_q <= cap_nx;
  end

endmodule

// File: tb/tb_board_access_arbiter.sv
// Self-checking bench for board_access_arbiter with a latency-accurate memory model
// and a scoreboard of expected read responses.
module tb_board_access_arbiter;

  localparam int N_REQ   = 5;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 8;
  localparam int MEM_LAT = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [N_REQ-1:0]        req, we;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ*DATA_W-1:0] wdata;
  logic                    hold;
  logic [N_REQ-1:0]        gnt, rvalid;
  logic [DATA_W-1:0]       rdata;
  logic                    busy, mem_en, mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  board_access_arbiter #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_addr(addr),
    .i_wdata(wdata), .i_hold(hold), .o_gnt(gnt), .o_rvalid(rvalid),
    .o_rdata(rdata), .o_busy(busy), .o_mem_en(mem_en), .o_mem_we(mem_we),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic mon_on = 1'b0;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] model_mem [1024];

  function automatic logic [7:0] pat(int a);
    return 8'(a) ^ 8'h99;
  endfunction

  // Memory: command sampled at the end of the enable cycle, data out MEM_LAT cycles later.
  logic       init_mem = 1'b0;
  logic [7:0] mem     [1024];
  logic [7:0] rd_pipe [MEM_LAT];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
    end else if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    rd_pipe[0] <= mem[mem_addr];
    for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[MEM_LAT-1];

  // Scoreboard and invariant monitor.
  always @(negedge clk) begin
    if (mon_on) begin
      n_tests++;
      if (gnt !== '0 && rvalid !== '0) begin
        n_fail++;
        $display("FAIL gnt_rvalid_overlap gnt=%b rvalid=%b want one of them zero", gnt, rvalid);
      end
      n_tests++;
      if (mem_en === 1'b1 && gnt === '0) begin
        n_fail++;
        $display("FAIL mem_en_outside_cmd mem_en=%b gnt=%b", mem_en, gnt);
      end
      if (rvalid !== '0) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_rvalid rvalid=%b rdata=%h want no response", rvalid, rdata);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (rvalid !== (5'b1 << e.idx) || rdata !== e.data) begin
            n_fail++;
            $display("FAIL rvalid_data got rvalid=%b rdata=%h want rvalid=%b rdata=%h",
                     rvalid, rdata, 5'b1 << e.idx, e.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int k, logic w, logic [9:0] a, logic [7:0] d);
    we[k]                   = w;
    addr[k*ADDR_W +: ADDR_W] = a;
    wdata[k*DATA_W +: DATA_W] = d;
    req[k]                  = 1'b1;
  endtask

  task automatic wait_gnt(output logic [N_REQ-1:0] g);
    int b = 0;
    g = '0;
    while (g == '0 && b < 40) begin
      tick();
      g = gnt;
      b++;
    end
    n_tests++;
    if (g == '0) begin
      n_fail++;
      $display("FAIL gnt_timeout got gnt=%b after %0d cycles want a grant", g, b);
    end
  endtask

  task automatic drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 40) begin
      tick();
      b++;
    end
    tick();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain %0d responses outstanding want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hold = 1'b0; req = '1; we = '0; addr = '0; wdata = '0;
    init_mem = 1'b1;
    tick(); tick();
    init_mem = 1'b0;
    n_tests++;
    if ({gnt, rvalid, busy, mem_en, mem_we} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl got gnt=%b rvalid=%b busy=%b en=%b we=%b want all 0",
               gnt, rvalid, busy, mem_en, mem_we);
    end
    n_tests++;
    if ({rdata, mem_addr, mem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_data got rdata=%h addr=%h wdata=%h want 0", rdata, mem_addr, mem_wdata);
    end
    n_tests++;
    if (dut.ptr !== '0) begin
      n_fail++;
      $display("FAIL reset_ptr got %0d want 0", dut.ptr);
    end
    req = '0;
    rst_n = 1'b1;
    mon_on = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    set_req(2, 1'b0, 10'h1A5, 8'h00);
    exp_q.push_back('{2, 8'h3C});
    tick();
    n_tests++;
    if (gnt !== 5'b00100 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'h1A5) begin
      n_fail++;
      $display("FAIL read_cmd got gnt=%b en=%b we=%b addr=%h want 00100 1 0 1a5",
               gnt, mem_en, mem_we, mem_addr);
    end
    req[2] = 1'b0;
    repeat (3) begin
      tick();
      n_tests++;
      if (rvalid !== '0) begin
        n_fail++;
        $display("FAIL read_early_rvalid got %b want 00000", rvalid);
      end
    end
    tick();
    n_tests++;
    if (rvalid !== 5'b00100 || rdata !== 8'h3C) begin
      n_fail++;
      $display("FAIL read_latency got rvalid=%b rdata=%h want 00100 3c", rvalid, rdata);
    end
    drain();
  endtask

  task automatic test_round_robin();
    int order[7] = '{0, 1, 2, 3, 4, 0, 1};
    int seen[$];
    int b = 0;
    logic chk_ptr = 1'b0;
    rst_n = 1'b0;
    tick();
    for (int k = 0; k < N_REQ; k++) set_req(k, 1'b0, 10'(k*64 + 7), 8'h00);
    foreach (order[i]) exp_q.push_back('{order[i], model_mem[10'(order[i]*64 + 7)]});
    rst_n = 1'b1;
    while (seen.size() < 7 && b < 100) begin
      tick();
      b++;
      if (chk_ptr) begin
        chk_ptr = 1'b0;
        n_tests++;
        if (dut.ptr !== '0) begin
          n_fail++;
          $display("FAIL rr_ptr_wrap got %0d want 0", dut.ptr);
        end
      end
      if (gnt !== '0) begin
        for (int k = 0; k < N_REQ; k++) if (gnt[k]) seen.push_back(k);
        if (seen.size() == 5) chk_ptr = 1'b1;
        if (seen.size() >= 7) req = '0;
      end
    end
    req = '0;
    n_tests++;
    if (seen.size() != 7) begin
      n_fail++;
      $display("FAIL rr_count got %0d grants want 7", seen.size());
    end else begin
      foreach (order[i]) begin
        n_tests++;
        if (seen[i] != order[i]) begin
          n_fail++;
          $display("FAIL rr_order grant %0d got idx %0d want %0d", i, seen[i], order[i]);
        end
      end
    end
    drain();
  endtask

  task automatic test_write_b2b();
    logic [N_REQ-1:0] g;
    set_req(4, 1'b1, 10'h3EF, 8'h11);
    model_mem[10'h3EF] = 8'h11;
    tick();
    n_tests++;
    if (gnt !== 5'b10000 || mem_en !== 1'b1 || mem_we !== 1'b1 ||
        mem_addr !== 10'h3EF || mem_wdata !== 8'h11) begin
      n_fail++;
      $display("FAIL write_cmd got gnt=%b en=%b we=%b addr=%h wdata=%h want 10000 1 1 3ef 11",
               gnt, mem_en, mem_we, mem_addr, mem_wdata);
    end
    set_req(4, 1'b1, 10'h3EE, 8'h22);
    model_mem[10'h3EE] = 8'h22;
    tick();
    n_tests++;
    if (gnt !== '0 || rvalid !== '0) begin
      n_fail++;
      $display("FAIL write_gap got gnt=%b rvalid=%b want 00000 00000", gnt, rvalid);
    end
    tick();
    n_tests++;
    if (gnt !== 5'b10000 || mem_we !== 1'b1 || mem_addr !== 10'h3EE || mem_wdata !== 8'h22) begin
      n_fail++;
      $display("FAIL write_b2b got gnt=%b we=%b addr=%h wdata=%h want 10000 1 3ee 22",
               gnt, mem_we, mem_addr, mem_wdata);
    end
    req[4] = 1'b0;
    repeat (2) tick();
    set_req(0, 1'b0, 10'h3EF, 8'h00);
    exp_q.push_back('{0, 8'h11});
    wait_gnt(g);
    req[0] = 1'b0;
    drain();
  endtask

  task automatic test_hold();
    hold = 1'b1;
    set_req(1, 1'b0, 10'h077, 8'h00);
    exp_q.push_back('{1, model_mem[10'h077]});
    repeat (10) begin
      tick();
      n_tests++;
      if (gnt !== '0 || mem_en !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_block got gnt=%b en=%b busy=%b want 0 0 0", gnt, mem_en, busy);
      end
    end
    hold = 1'b0;
    tick();
    n_tests++;
    if (gnt !== 5'b00010) begin
      n_fail++;
      $display("FAIL hold_release got gnt=%b want 00010", gnt);
    end
    req[1] = 1'b0;
    drain();
  endtask

  task automatic test_reset_in_wait();
    int rv_seen = 0;
    set_req(3, 1'b0, 10'h123, 8'h00);
    exp_q.push_back('{3, model_mem[10'h123]});
    tick();
    n_tests++;
    if (gnt !== 5'b01000) begin
      n_fail++;
      $display("FAIL rst_wait_gnt got %b want 01000", gnt);
    end
    req[3] = 1'b0;
    tick();
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_wait_busy got %b want 1", busy);
    end
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    n_tests++;
    if (gnt !== '0 || rvalid !== '0 || busy !== 1'b0 || dut.ptr !== '0) begin
      n_fail++;
      $display("FAIL rst_wait_clear got gnt=%b rvalid=%b busy=%b ptr=%0d want 0 0 0 0",
               gnt, rvalid, busy, dut.ptr);
    end
    rst_n = 1'b1;
    repeat (8) begin
      tick();
      if (rvalid !== '0) rv_seen++;
    end
    n_tests++;
    if (rv_seen != 0) begin
      n_fail++;
      $display("FAIL rst_wait_discard got %0d rvalid cycles want 0", rv_seen);
    end
  endtask

  task automatic test_wrap();
    logic [N_REQ-1:0] g;
    set_req(2, 1'b1, 10'h200, 8'h5E);
    model_mem[10'h200] = 8'h5E;
    tick();
    req[2] = 1'b0;
    tick();
    n_tests++;
    if (dut.ptr !== 3'd3) begin
      n_fail++;
      $display("FAIL wrap_ptr got %0d want 3", dut.ptr);
    end
    set_req(0, 1'b0, 10'h010, 8'h00);
    set_req(2, 1'b0, 10'h020, 8'h00);
    exp_q.push_back('{0, model_mem[10'h010]});
    exp_q.push_back('{2, model_mem[10'h020]});
    wait_gnt(g);
    req[0] = 1'b0;
    n_tests++;
    if (g !== 5'b00001) begin
      n_fail++;
      $display("FAIL wrap_first got gnt=%b want 00001", g);
    end
    wait_gnt(g);
    req[2] = 1'b0;
    n_tests++;
    if (g !== 5'b00100) begin
      n_fail++;
      $display("FAIL wrap_second got gnt=%b want 00100", g);
    end
    drain();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) model_mem[i] = pat(i);
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_b2b();
    test_hold();
    test_reset_in_wait();
    test_wrap();
    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
